// File: rtl/rcpu_mem_pkg.sv
// Shared types and constants for the RCPU memory responder:
// FSM encoding, I/O register offsets and address-region decode.
package rcpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } memState_e;

  typedef enum logic [1:0] {
    RGN_RAM      = 2'd0,
    RGN_IO       = 2'd1,
    RGN_UNMAPPED = 2'd2
  } region_e;

  localparam int IO_OFFSET_W = 8;

  localparam logic [IO_OFFSET_W-1:0] IO_OUT = 8'd0;
  localparam logic [IO_OFFSET_W-1:0] IO_IN  = 8'd1;
  localparam logic [IO_OFFSET_W-1:0] IO_CNT = 8'd2;

endpackage

// File: rtl/rcpu_mmio_regs.sv
// Memory-mapped I/O registers: output latch, synchronised input pins and
// a free-running cycle counter that is cleared by any write to its offset.
module rcpu_mmio_regs
  import rcpu_mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IO_OFFSET_W-1:0] offset,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W-1:0]      io_in,
  output logic [DATA_W-1:0]      io_out,
  output logic [DATA_W-1:0]      rd_data
);

  logic [DATA_W-1:0] ioOut_r;
  logic [DATA_W-1:0] sync1_r;
  logic [DATA_W-1:0] sync2_r;
  logic [DATA_W-1:0] cnt_r;

  // Register state; a counter clear wins over the same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ioOut_r <= {DATA_W{1'b0}};
      sync1_r <= {DATA_W{1'b0}};
      sync2_r <= {DATA_W{1'b0}};
      cnt_r   <= {DATA_W{1'b0}};
    end else begin
      sync1_r <= io_in;
      sync2_r <= sync1_r;
      if (wr_en && (offset == IO_CNT)) begin
        cnt_r <= {DATA_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + DATA_W'(1);
      end
      if (wr_en && (offset == IO_OUT)) begin
        ioOut_r <= wdata;
      end else begin
        ioOut_r <= ioOut_r;
      end
    end
  end

  // Read mux; unassigned offsets read as zero.
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    case (offset)
      IO_OUT:  rd_data = ioOut_r;
      IO_IN:   rd_data = sync2_r;
      IO_CNT:  rd_data = cnt_r;
      default: rd_data = {DATA_W{1'b0}};
    endcase
  end

  assign io_out = ioOut_r;

endmodule

// File: rtl/rcpu_mem_responder.sv
// Memory-side responder for the RCPU: latches a request, inserts wait states,
// decodes RAM / MMIO / unmapped and returns a one-cycle ready pulse.
module rcpu_mem_responder
  import rcpu_mem_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                RAM_WORDS   = 4096,
  parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFF00,
  parameter int                WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_WORDS);

  memState_e         curState_r;
  memState_e         nextState_s;
  region_e           region_s;
  logic              weLat_r;
  logic [ADDR_W-1:0] addrLat_r;
  logic [DATA_W-1:0] wdataLat_r;
  logic [3:0]        waitCnt_r;
  logic              ready_r;
  logic              err_r;
  logic              respRamRd_r;
  logic [DATA_W-1:0] rdataHold_r;
  logic              ioWrEn_s;
  logic [IO_OFFSET_W-1:0] ioOffset_s;
  logic [DATA_W-1:0] ioRdData_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState_r <= ST_IDLE;
    end else begin
      curState_r <= nextState_s;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState_s = curState_r;
    case (curState_r)
      ST_IDLE: begin
        if (req) begin
          nextState_s = (WAIT_INIT == 4'd0) ? ST_ACCESS : ST_WAIT;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (waitCnt_r <= 4'd1) begin
          nextState_s = ST_ACCESS;
        end else begin
          nextState_s = ST_WAIT;
        end
      end
      ST_ACCESS: nextState_s = ST_RESP;
      ST_RESP:   nextState_s = ST_IDLE;
      default:   nextState_s = ST_IDLE;
    endcase
  end

  // Request latch and wait-state counter; inputs are ignored once sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weLat_r    <= 1'b0;
      addrLat_r  <= {ADDR_W{1'b0}};
      wdataLat_r <= {DATA_W{1'b0}};
      waitCnt_r  <= 4'd0;
    end else if ((curState_r == ST_IDLE) && req) begin
      weLat_r    <= we;
      addrLat_r  <= addr;
      wdataLat_r <= wdata;
      waitCnt_r  <= WAIT_INIT;
    end else if (curState_r == ST_WAIT) begin
      waitCnt_r  <= waitCnt_r - 4'd1;
    end else begin
      waitCnt_r  <= waitCnt_r;
    end
  end

  // Region decode of the latched address.
  always_comb begin
    region_s = RGN_UNMAPPED;
    if ({1'b0, addrLat_r} < RAM_LIMIT) begin
      region_s = RGN_RAM;
    end else if (addrLat_r >= IO_BASE) begin
      region_s = RGN_IO;
    end else begin
      region_s = RGN_UNMAPPED;
    end
  end

  assign ioOffset_s = IO_OFFSET_W'(addrLat_r - IO_BASE);
  assign ioWrEn_s   = (curState_r == ST_ACCESS) && (region_s == RGN_IO) && weLat_r;

  rcpu_mmio_regs #(.DATA_W(DATA_W)) u_mmio (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ioWrEn_s),
    .offset  (ioOffset_s),
    .wdata   (wdataLat_r),
    .io_in   (io_in),
    .io_out  (io_out),
    .rd_data (ioRdData_s)
  );

  assign ram_en    = (curState_r == ST_ACCESS) && (region_s == RGN_RAM);
  assign ram_we    = ram_en && weLat_r;
  assign ram_addr  = addrLat_r;
  assign ram_wdata = wdataLat_r;

  // Response registers, loaded on the ACCESS->RESP edge and cleared otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r     <= 1'b0;
      err_r       <= 1'b0;
      respRamRd_r <= 1'b0;
      rdataHold_r <= {DATA_W{1'b0}};
    end else if (curState_r == ST_ACCESS) begin
      ready_r     <= 1'b1;
      err_r       <= (region_s == RGN_UNMAPPED);
      respRamRd_r <= (region_s == RGN_RAM) && !weLat_r;
      rdataHold_r <= ((region_s == RGN_IO) && !weLat_r) ? ioRdData_s : {DATA_W{1'b0}};
    end else begin
      ready_r     <= 1'b0;
      err_r       <= 1'b0;
      respRamRd_r <= 1'b0;
      rdataHold_r <= {DATA_W{1'b0}};
    end
  end

  // RAM read data is already registered by the RAM and only arrives in RESP,
  // so it is steered through by a registered select.
  assign rdata = respRamRd_r ? ram_rdata : rdataHold_r;
  assign ready = ready_r;
  assign err   = err_r;

endmodule

// File: tb/tb_rcpu_mem_responder.sv
// Directed self-checking bench for rcpu_mem_responder with a behavioural
// synchronous RAM; two extra instances cover zero and three wait states.
module tb_rcpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, req0 = 1'b0, req3 = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000, wdata = 16'h0000, ioIn = 16'h0000;
  logic [15:0] rdata, ramAddr, ramWdata, ioOut;
  logic        ready, err, ramEn, ramWe;
  logic [15:0] ramRdata;
  logic [15:0] mem [0:65535];

  logic [15:0] rdata0, ramAddr0, ramWdata0, ioOut0, ramRd0;
  logic        ready0, err0, ramEn0, ramWe0;
  logic [15:0] rdata3, ramAddr3, ramWdata3, ioOut3, ramRd3;
  logic        ready3, err3, ramEn3, ramWe3;

  int nChecks = 0;
  int nFail = 0;
  int ramEnCnt = 0, ramWeCnt = 0, readyCnt = 0;

  rcpu_mem_responder #(.WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .ram_en(ramEn), .ram_we(ramWe),
    .ram_addr(ramAddr), .ram_wdata(ramWdata), .ram_rdata(ramRdata),
    .io_in(ioIn), .io_out(ioOut)
  );

  rcpu_mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(1'b0), .addr(16'h0000), .wdata(16'h0000),
    .rdata(rdata0), .ready(ready0), .err(err0), .ram_en(ramEn0), .ram_we(ramWe0),
    .ram_addr(ramAddr0), .ram_wdata(ramWdata0), .ram_rdata(ramRd0),
    .io_in(ioIn), .io_out(ioOut0)
  );

  rcpu_mem_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(1'b0), .addr(16'h0000), .wdata(16'h0000),
    .rdata(rdata3), .ready(ready3), .err(err3), .ram_en(ramEn3), .ram_we(ramWe3),
    .ram_addr(ramAddr3), .ram_wdata(ramWdata3), .ram_rdata(ramRd3),
    .io_in(ioIn), .io_out(ioOut3)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAMs with registered read data.
  always @(posedge clk) begin
    if (ramEn) begin
      if (ramWe) mem[ramAddr] <= ramWdata;
      ramRdata <= mem[ramAddr];
    end
    if (ramEn0) ramRd0 <= 16'hC0DE;
    if (ramEn3) ramRd3 <= 16'hC0D3;
  end

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (ramEn) ramEnCnt <= ramEnCnt + 1;
    if (ramWe) ramWeCnt <= ramWeCnt + 1;
    if (ready) readyCnt <= readyCnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from just after a rising edge; returns the cycle index
  // (relative to the sampling cycle) in which ready was seen.
  task automatic doReq(input logic w, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd, output logic e);
    req = 1'b1; we = w; addr = a; wdata = d;
    lat = 0;
    @(negedge clk);
    while (!ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata;
    e  = err;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] rd;
    logic e;
    int snapA, snapB, nRdy0, nRdy3, first0, first3;
    logic [15:0] b2bAddr [3];
    logic [15:0] b2bData [3];

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ram_en", {31'd0, ramEn}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_io_out", {16'd0, ioOut}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Cycle-accurate write; req and addr are disturbed after sampling
    req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'h1234;
    @(negedge clk);
    check("wr_c0_ram_en", {31'd0, ramEn}, 32'd0);
    @(posedge clk); #1;
    req = 1'b0; addr = 16'hFFFF; wdata = 16'h0000;
    @(negedge clk);
    check("wr_c1_ram_en", {31'd0, ramEn}, 32'd0);
    check("wr_c1_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check("wr_c2_ram_en", {31'd0, ramEn}, 32'd1);
    check("wr_c2_ram_we", {31'd0, ramWe}, 32'd1);
    check("wr_c2_ram_addr", {16'd0, ramAddr}, 32'h0010);
    check("wr_c2_ram_wdata", {16'd0, ramWdata}, 32'h1234);
    @(negedge clk);
    check("wr_c3_ready", {31'd0, ready}, 32'd1);
    check("wr_c3_err", {31'd0, err}, 32'd0);
    check("wr_c3_ram_en", {31'd0, ramEn}, 32'd0);
    @(negedge clk);
    check("wr_c4_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;

    doReq(1'b0, 16'h0010, 16'h0000, lat, rd, e);
    check("rd0010_lat", lat, 32'd3);
    check("rd0010_data", {16'd0, rd}, 32'h1234);
    check("rd0010_err", {31'd0, e}, 32'd0);

    // MMIO output register
    doReq(1'b1, 16'hFF00, 16'hA5A5, lat, rd, e);
    check("wrFF00_lat", lat, 32'd3);
    check("wrFF00_io_out", {16'd0, ioOut}, 32'hA5A5);
    doReq(1'b0, 16'hFF00, 16'h0000, lat, rd, e);
    check("rdFF00_data", {16'd0, rd}, 32'hA5A5);

    // Synchronised input pins; a write to this RO offset is ignored
    ioIn = 16'h00C3;
    repeat (2) @(posedge clk); #1;
    doReq(1'b0, 16'hFF01, 16'h0000, lat, rd, e);
    check("rdFF01_data", {16'd0, rd}, 32'h00C3);
    doReq(1'b1, 16'hFF01, 16'hFFFF, lat, rd, e);
    doReq(1'b0, 16'hFF01, 16'h0000, lat, rd, e);
    check("rdFF01_ro", {16'd0, rd}, 32'h00C3);
    check("rdFF01_io_out", {16'd0, ioOut}, 32'hA5A5);

    // Unmapped regions and the RAM / MMIO boundaries
    snapA = ramEnCnt;
    doReq(1'b0, 16'h2000, 16'h0000, lat, rd, e);
    check("rd2000_lat", lat, 32'd3);
    check("rd2000_err", {31'd0, e}, 32'd1);
    check("rd2000_data", {16'd0, rd}, 32'h0000);
    doReq(1'b0, 16'h1000, 16'h0000, lat, rd, e);
    check("rd1000_err", {31'd0, e}, 32'd1);
    doReq(1'b0, 16'hFEFF, 16'h0000, lat, rd, e);
    check("rdFEFF_err", {31'd0, e}, 32'd1);
    check("unmapped_ram_en", ramEnCnt - snapA, 32'd0);
    doReq(1'b0, 16'hFF10, 16'h0000, lat, rd, e);
    check("rdFF10_data", {16'd0, rd}, 32'h0000);
    check("rdFF10_err", {31'd0, e}, 32'd0);
    doReq(1'b1, 16'h0FFF, 16'h7777, lat, rd, e);
    doReq(1'b0, 16'h0FFF, 16'h0000, lat, rd, e);
    check("rd0FFF_data", {16'd0, rd}, 32'h7777);
    check("rd0FFF_err", {31'd0, e}, 32'd0);

    // Counter clear then read in the very next transaction: 3 cycles elapse
    doReq(1'b1, 16'hFF02, 16'h1234, lat, rd, e);
    check("wrFF02_err", {31'd0, e}, 32'd0);
    doReq(1'b0, 16'hFF02, 16'h0000, lat, rd, e);
    check("rdFF02_cnt", {16'd0, rd}, 32'h0003);

    // Reset during WAIT of a write aborts it
    doReq(1'b1, 16'h0020, 16'hBEEF, lat, rd, e);
    snapA = ramWeCnt;
    snapB = readyCnt;
    req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h1111;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("abort_io_out", {16'd0, ioOut}, 32'h0000);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ram_we", ramWeCnt - snapA, 32'd0);
    check("abort_ready", readyCnt - snapB, 32'd0);
    doReq(1'b0, 16'h0020, 16'h0000, lat, rd, e);
    check("rd0020_old", {16'd0, rd}, 32'hBEEF);

    // req held high: one ready per 4 cycles, each with its own sampled addr
    b2bAddr[0] = 16'h0010; b2bData[0] = 16'h1234;
    b2bAddr[1] = 16'h0020; b2bData[1] = 16'hBEEF;
    b2bAddr[2] = 16'h0FFF; b2bData[2] = 16'h7777;
    snapB = readyCnt;
    req = 1'b1; we = 1'b0;
    for (int c = 0; c < 12; c++) begin
      addr = ((c % 4) == 0) ? b2bAddr[c / 4] : 16'h2000;
      @(negedge clk);
      if (ready) begin
        check("b2b_phase", c % 4, 32'd3);
        check("b2b_data", {16'd0, rdata}, {16'd0, b2bData[c / 4]});
        check("b2b_err", {31'd0, err}, 32'd0);
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    check("b2b_ready_count", readyCnt - snapB, 32'd3);

    // Zero and three wait states: ready at N+2 and N+5, one pulse each
    nRdy0 = 0; nRdy3 = 0; first0 = -1; first3 = -1;
    req0 = 1'b1; req3 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ready0) begin
        nRdy0++;
        if (first0 < 0) first0 = c;
        check("ws0_data", {16'd0, rdata0}, 32'hC0DE);
        check("ws0_err", {31'd0, err0}, 32'd0);
      end
      if (ready3) begin
        nRdy3++;
        if (first3 < 0) first3 = c;
        check("ws3_data", {16'd0, rdata3}, 32'hC0D3);
        check("ws3_err", {31'd0, err3}, 32'd0);
      end
      if (ramEn0) check("ws0_ram", {15'd0, ramWe0, ramAddr0}, 32'h0);
      if (ramEn3) check("ws3_ram", {15'd0, ramWe3, ramAddr3}, 32'h0);
      @(posedge clk); #1;
      req0 = 1'b0; req3 = 1'b0;
    end
    check("ws0_latency", first0, 32'd2);
    check("ws3_latency", first3, 32'd5);
    check("ws0_pulses", nRdy0, 32'd1);
    check("ws3_pulses", nRdy3, 32'd1);
    check("ws_io_out", {ioOut0, ioOut3}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
